// File: rtl/ooo_pkg.sv
// Shared out-of-order core types, parameter defaults and small helpers.
package ooo_pkg;

  localparam int DEF_NUM_PREG = 64;
  localparam int DEF_NUM_CKPT = 4;

  localparam int DEF_NUM_AREG = 16;
  localparam int DEF_ALLOC_W  = 2;
  localparam int DEF_REL_W    = 2;

  localparam int PREG_W = $clog2(DEF_NUM_PREG);
  localparam int CKPT_W = $clog2(DEF_NUM_CKPT);

  // Widest vector popcount accepts; callers zero-extend to this width.
  localparam int MAX_PREG = 1024;

  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [CKPT_W-1:0] ckpt_id_t;

  function automatic int unsigned popcount(input logic [MAX_PREG-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_PREG; i++) n += 32'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/lowest_n_picker.sv
// Returns the K lowest set-bit indices of an N-bit vector and whether at least K bits are set.
module lowest_n_picker #(
  parameter int N = 64,
  parameter int K = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]          vec,
  output logic [K-1:0][IW-1:0]  idx,
  output logic                  at_least_k
);

  localparam int FW = $clog2(N + 1);

  logic [FW-1:0] found;

  always_comb begin
    idx   = '0;
    found = '0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        for (int k = 0; k < K; k++) begin
          if (found == FW'(k)) idx[k] = IW'(i);
        end
        found = found + FW'(1);
      end
    end
  end

  assign at_least_k = (found >= FW'(K));

endmodule

// File: rtl/phys_reg_free_list.sv
// Physical-register free list: multi-port allocate/release with per-branch
// checkpoints that reclaim wrong-path allocations in a single cycle.
module phys_reg_free_list
  import ooo_pkg::*;
#(
  parameter int NUM_PREG = DEF_NUM_PREG,
  parameter int NUM_AREG = DEF_NUM_AREG,
  parameter int ALLOC_W  = DEF_ALLOC_W,
  parameter int REL_W    = DEF_REL_W,
  parameter int NUM_CKPT = DEF_NUM_CKPT,
  localparam int PW = $clog2(NUM_PREG),
  localparam int CW = $clog2(NUM_CKPT)
) (
  input  logic                       clk,
  input  logic                       n_rst,
  // Handshake: alloc_preg/alloc_ready are valid every cycle from registered
  // state. A port allocates at posedge iff alloc_req[i] && alloc_ready &&
  // !ckpt_restore; requesters must hold off while alloc_ready is low.
  input  logic [ALLOC_W-1:0]         alloc_req,
  output logic                       alloc_ready,
  output logic [ALLOC_W-1:0][PW-1:0] alloc_preg,
  input  logic [REL_W-1:0]           rel_valid,
  input  logic [REL_W-1:0][PW-1:0]   rel_preg,
  input  logic                       ckpt_take,
  input  logic [CW-1:0]              ckpt_take_id,
  input  logic                       ckpt_restore,
  input  logic [CW-1:0]              ckpt_restore_id,
  input  logic [NUM_CKPT-1:0]        ckpt_kill,
  input  logic                       ckpt_release,
  input  logic [CW-1:0]              ckpt_release_id,
  output logic [PW:0]                free_count,
  output logic                       err
);

  localparam logic [NUM_PREG-1:0] RESET_FREE =
    {{(NUM_PREG-NUM_AREG){1'b1}}, {NUM_AREG{1'b0}}};

  logic [NUM_PREG-1:0] free_vec, free_nxt;
  logic [NUM_PREG-1:0] alloc_set, rel_set;
  logic [NUM_CKPT-1:0] ckpt_valid, valid_nxt;
  logic [NUM_PREG-1:0] ckpt_mask [NUM_CKPT];
  logic [NUM_PREG-1:0] mask_nxt  [NUM_CKPT];
  logic                take_eff;
  logic                err_nxt;

  lowest_n_picker #(
    .N (NUM_PREG),
    .K (ALLOC_W)
  ) u_pick (
    .vec        (free_vec),
    .idx        (alloc_preg),
    .at_least_k (alloc_ready)
  );

  always_comb begin
    alloc_set = '0;
    rel_set   = '0;
    err_nxt   = err;

    // A restore squashes this cycle's allocations entirely.
    for (int i = 0; i < ALLOC_W; i++) begin
      if (alloc_ready && !ckpt_restore && alloc_req[i]) alloc_set[alloc_preg[i]] = 1'b1;
    end

    for (int i = 0; i < REL_W; i++) begin
      if (rel_valid[i]) begin
        if (free_vec[rel_preg[i]]) err_nxt = 1'b1;
        for (int j = 0; j < i; j++) begin
          if (rel_valid[j] && (rel_preg[j] == rel_preg[i])) err_nxt = 1'b1;
        end
        rel_set[rel_preg[i]] = 1'b1;
      end
    end

    take_eff = ckpt_take && !ckpt_restore && !ckpt_valid[ckpt_take_id];
    if (ckpt_take && !ckpt_restore && ckpt_valid[ckpt_take_id]) err_nxt = 1'b1;
    if (ckpt_restore && !ckpt_valid[ckpt_restore_id])           err_nxt = 1'b1;
    if (ckpt_release && !ckpt_valid[ckpt_release_id])           err_nxt = 1'b1;

    free_nxt = (free_vec & ~alloc_set) | rel_set;
    if (ckpt_restore) free_nxt = free_nxt | ckpt_mask[ckpt_restore_id];

    valid_nxt = ckpt_valid;
    if (ckpt_release) valid_nxt[ckpt_release_id] = 1'b0;
    if (take_eff)     valid_nxt[ckpt_take_id]    = 1'b1;
    if (ckpt_restore) valid_nxt = valid_nxt & ~ckpt_kill;

    // Only checkpoints already open record this cycle's allocations.
    for (int c = 0; c < NUM_CKPT; c++) begin
      mask_nxt[c] = ckpt_mask[c] | (ckpt_valid[c] ? alloc_set : '0);
      if (take_eff && (ckpt_take_id == CW'(c))) mask_nxt[c] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      free_vec   <= RESET_FREE;
      ckpt_valid <= '0;
      err        <= 1'b0;
      free_count <= (PW+1)'(NUM_PREG - NUM_AREG);
      for (int c = 0; c < NUM_CKPT; c++) ckpt_mask[c] <= '0;
    end else begin
      free_vec   <= free_nxt;
      ckpt_valid <= valid_nxt;
      err        <= err_nxt;
      free_count <= (PW+1)'(popcount(MAX_PREG'(free_nxt)));
      for (int c = 0; c < NUM_CKPT; c++) ckpt_mask[c] <= mask_nxt[c];
    end
  end

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Bench for phys_reg_free_list: directed scenarios plus random legal traffic against a behavioural model.
module tb_phys_reg_free_list;
  import ooo_pkg::*;

  localparam int NP = 64;
  localparam int NA = 16;
  localparam int AW = 2;
  localparam int RW = 2;
  localparam int NC = 4;
  localparam int PW = $clog2(NP);
  localparam int CW = $clog2(NC);

  logic                  clk = 1'b0;
  logic                  n_rst;
  logic [AW-1:0]         alloc_req;
  logic                  alloc_ready;
  logic [AW-1:0][PW-1:0] alloc_preg;
  logic [RW-1:0]         rel_valid;
  logic [RW-1:0][PW-1:0] rel_preg;
  logic                  ckpt_take;
  logic [CW-1:0]         ckpt_take_id;
  logic                  ckpt_restore;
  logic [CW-1:0]         ckpt_restore_id;
  logic [NC-1:0]         ckpt_kill;
  logic                  ckpt_release;
  logic [CW-1:0]         ckpt_release_id;
  logic [PW:0]           free_count;
  logic                  err;

  phys_reg_free_list #(
    .NUM_PREG (NP), .NUM_AREG (NA), .ALLOC_W (AW), .REL_W (RW), .NUM_CKPT (NC)
  ) dut (
    .clk             (clk),
    .n_rst           (n_rst),
    .alloc_req       (alloc_req),
    .alloc_ready     (alloc_ready),
    .alloc_preg      (alloc_preg),
    .rel_valid       (rel_valid),
    .rel_preg        (rel_preg),
    .ckpt_take       (ckpt_take),
    .ckpt_take_id    (ckpt_take_id),
    .ckpt_restore    (ckpt_restore),
    .ckpt_restore_id (ckpt_restore_id),
    .ckpt_kill       (ckpt_kill),
    .ckpt_release    (ckpt_release),
    .ckpt_release_id (ckpt_release_id),
    .free_count      (free_count),
    .err             (err)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  bit m_free  [NP];
  bit m_valid [NC];
  bit m_mask  [NC][NP];
  bit m_err;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    alloc_req       = '0;
    rel_valid       = '0;
    rel_preg        = '0;
    ckpt_take       = 1'b0;
    ckpt_take_id    = '0;
    ckpt_restore    = 1'b0;
    ckpt_restore_id = '0;
    ckpt_kill       = '0;
    ckpt_release    = 1'b0;
    ckpt_release_id = '0;
  endtask

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < NP; i++) n += int'(m_free[i]);
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NP; i++) m_free[i] = (i >= NA);
    for (int c = 0; c < NC; c++) begin
      m_valid[c] = 1'b0;
      for (int i = 0; i < NP; i++) m_mask[c][i] = 1'b0;
    end
    m_err = 1'b0;
  endtask

  // Entered just after a negedge with inputs set; returns at the next negedge with inputs idle.
  task automatic step();
    int  pk[AW];
    int  cnt;
    bit  rdy;
    bit  nf[NP];
    bit  nv[NC];
    bit  nm[NC][NP];
    bit  ne;
    #1;
    cnt = 0;
    for (int k = 0; k < AW; k++) pk[k] = 0;
    for (int i = 0; i < NP; i++) begin
      if (m_free[i]) begin
        if (cnt < AW) pk[cnt] = i;
        cnt++;
      end
    end
    rdy = (cnt >= AW);
    exp_q.push_back(32'(rdy));
    if (rdy) for (int k = 0; k < AW; k++) exp_q.push_back(32'(pk[k]));

    check_val("alloc_ready", 32'(alloc_ready), exp_q.pop_front());
    if (rdy) for (int k = 0; k < AW; k++)
      check_val($sformatf("alloc_preg%0d", k), 32'(alloc_preg[k]), exp_q.pop_front());

    nf = m_free; nv = m_valid; nm = m_mask; ne = m_err;
    for (int r = 0; r < RW; r++) begin
      if (rel_valid[r]) begin
        if (m_free[rel_preg[r]]) ne = 1'b1;
        for (int q = 0; q < r; q++)
          if (rel_valid[q] && rel_preg[q] == rel_preg[r]) ne = 1'b1;
      end
    end
    if (rdy && !ckpt_restore) begin
      for (int k = 0; k < AW; k++) begin
        if (alloc_req[k]) begin
          nf[pk[k]] = 1'b0;
          for (int c = 0; c < NC; c++) if (m_valid[c]) nm[c][pk[k]] = 1'b1;
        end
      end
    end
    for (int r = 0; r < RW; r++) if (rel_valid[r]) nf[rel_preg[r]] = 1'b1;
    if (ckpt_release) begin
      if (!m_valid[ckpt_release_id]) ne = 1'b1;
      nv[ckpt_release_id] = 1'b0;
    end
    if (ckpt_take && !ckpt_restore) begin
      if (m_valid[ckpt_take_id]) ne = 1'b1;
      else begin
        nv[ckpt_take_id] = 1'b1;
        for (int i = 0; i < NP; i++) nm[ckpt_take_id][i] = 1'b0;
      end
    end
    if (ckpt_restore) begin
      if (!m_valid[ckpt_restore_id]) ne = 1'b1;
      for (int i = 0; i < NP; i++) if (m_mask[ckpt_restore_id][i]) nf[i] = 1'b1;
      for (int c = 0; c < NC; c++) if (ckpt_kill[c]) nv[c] = 1'b0;
    end

    @(posedge clk);
    m_free = nf; m_valid = nv; m_mask = nm; m_err = ne;
    @(negedge clk);
    set_idle();
    check_val("free_count", 32'(free_count), 32'(model_count()));
    check_val("err", 32'(err), 32'(m_err));
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    set_idle();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    model_reset();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int pick;
  int ok;

  initial begin
    set_idle();
    do_reset();

    check_val("rst_free_count", 32'(free_count), 48);
    check_val("rst_ready", 32'(alloc_ready), 1);
    check_val("rst_preg0", 32'(alloc_preg[0]), 16);
    check_val("rst_preg1", 32'(alloc_preg[1]), 17);
    check_val("rst_err", 32'(err), 0);

    // Two-port grant and zero-latency refresh
    alloc_req = 2'b11;
    step();
    check_val("s1_count", 32'(free_count), 46);
    check_val("s1_preg0", 32'(alloc_preg[0]), 18);
    check_val("s1_preg1", 32'(alloc_preg[1]), 19);

    // Drain to the empty boundary with a same-cycle release
    do_reset();
    for (int n = 0; n < 22; n++) begin
      alloc_req = 2'b11;
      step();
    end
    alloc_req = 2'b01;
    step();
    check_val("s2_count3", 32'(free_count), 3);
    alloc_req    = 2'b11;
    rel_valid[0] = 1'b1;
    rel_preg[0]  = PW'(20);
    #1;
    check_val("s2_no20_p0", 32'(alloc_preg[0]), 61);
    check_val("s2_no20_p1", 32'(alloc_preg[1]), 62);
    step();
    check_val("s2_20_next", 32'(alloc_preg[0]), 20);
    check_val("s2_ready2", 32'(alloc_ready), 1);
    alloc_req = 2'b01;
    step();
    check_val("s2_ready_low", 32'(alloc_ready), 0);
    check_val("s2_count1", 32'(free_count), 1);
    alloc_req = 2'b11;
    step();
    check_val("s2_stall_count", 32'(free_count), 1);

    // Nested checkpoints, restore to the older one
    do_reset();
    ckpt_take = 1'b1; ckpt_take_id = 2'd1;
    step();
    alloc_req = 2'b11;
    step();
    ckpt_take = 1'b1; ckpt_take_id = 2'd2;
    step();
    alloc_req = 2'b01;
    step();
    check_val("s3_pre_count", 32'(free_count), 45);
    ckpt_restore = 1'b1; ckpt_restore_id = 2'd1; ckpt_kill = 4'b0110;
    step();
    check_val("s3_count", 32'(free_count), 48);
    check_val("s3_preg0", 32'(alloc_preg[0]), 16);
    check_val("s3_preg1", 32'(alloc_preg[1]), 17);
    ckpt_release = 1'b1; ckpt_release_id = 2'd2;
    step();
    check_val("s3_killed_err", 32'(err), 1);

    // Restore suppresses allocation but honours a release
    do_reset();
    ckpt_take = 1'b1; ckpt_take_id = 2'd0;
    step();
    alloc_req = 2'b11;
    step();
    alloc_req = 2'b11;
    ckpt_restore = 1'b1; ckpt_restore_id = 2'd0; ckpt_kill = 4'b0001;
    rel_valid[0] = 1'b1; rel_preg[0] = PW'(5);
    step();
    check_val("s4_count", 32'(free_count), 49);
    check_val("s4_preg0", 32'(alloc_preg[0]), 5);
    check_val("s4_err", 32'(err), 0);

    // Same-cycle take + allocation is not reclaimed
    do_reset();
    ckpt_take = 1'b1; ckpt_take_id = 2'd0; alloc_req = 2'b01;
    step();
    ckpt_restore = 1'b1; ckpt_restore_id = 2'd0; ckpt_kill = 4'b0001;
    step();
    check_val("s5_preg0", 32'(alloc_preg[0]), 17);
    check_val("s5_count", 32'(free_count), 47);

    // Sticky error on double free
    do_reset();
    rel_valid[0] = 1'b1; rel_preg[0] = PW'(30);
    step();
    check_val("s6_err_set", 32'(err), 1);
    idle_cycles(3);
    check_val("s6_err_held", 32'(err), 1);
    do_reset();
    check_val("s6_err_clr", 32'(err), 0);

    // Random legal traffic
    do_reset();
    for (int n = 0; n < 300; n++) begin
      alloc_req = AW'($urandom_range(0, 3));
      for (int r = 0; r < RW; r++) begin
        if ($urandom_range(0, 2) == 0) begin
          for (int t = 0; t < 8; t++) begin
            pick = int'($urandom_range(0, NP - 1));
            ok = int'(!m_free[pick]);
            for (int q = 0; q < r; q++) if (rel_valid[q] && rel_preg[q] == PW'(pick)) ok = 0;
            if (ok != 0) begin
              rel_valid[r] = 1'b1;
              rel_preg[r]  = PW'(pick);
              break;
            end
          end
        end
      end
      pick = int'($urandom_range(0, NC - 1));
      if ($urandom_range(0, 7) == 0 && m_valid[pick]) begin
        ckpt_restore    = 1'b1;
        ckpt_restore_id = CW'(pick);
        ckpt_kill       = NC'(1) << pick;
        for (int c = 0; c < NC; c++) if (m_valid[c] && $urandom_range(0, 1) == 1) ckpt_kill[c] = 1'b1;
      end else if ($urandom_range(0, 2) == 0 && !m_valid[pick]) begin
        ckpt_take    = 1'b1;
        ckpt_take_id = CW'(pick);
      end
      pick = int'($urandom_range(0, NC - 1));
      if ($urandom_range(0, 5) == 0 && m_valid[pick] && !(ckpt_take && ckpt_take_id == CW'(pick))) begin
        ckpt_release    = 1'b1;
        ckpt_release_id = CW'(pick);
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
